// File: rtl/phase_sequencer_if.sv
// Sensor inputs and lamp/countdown outputs of phase_sequencer.
// With PREEMPT_EN defined the bundle also carries preempt_req / preempt_phase.
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = 2,
    parameter int TIMER_W    = 8
);
    logic [NUM_PHASES-1:0] car_sensor;
    logic [NUM_PHASES-1:0] ped_button;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] walk;
    logic [NUM_PHASES-1:0] hand;
    logic [TIMER_W-1:0]    countdown;
    logic [PH_W-1:0]       active_phase;
    logic                  tick;
`ifdef PREEMPT_EN
    logic                  preempt_req;
    logic [PH_W-1:0]       preempt_phase;

    modport master (
        output car_sensor, ped_button, preempt_req, preempt_phase,
        input  green, yellow, red, walk, hand, countdown, active_phase, tick
    );
    modport slave (
        input  car_sensor, ped_button, preempt_req, preempt_phase,
        output green, yellow, red, walk, hand, countdown, active_phase, tick
    );
`else
    modport master (
        output car_sensor, ped_button,
        input  green, yellow, red, walk, hand, countdown, active_phase, tick
    );
    modport slave (
        input  car_sensor, ped_button,
        output green, yellow, red, walk, hand, countdown, active_phase, tick
    );
`endif
endinterface

// File: rtl/phase_sequencer.sv
// Demand-driven GREEN -> YELLOW -> ALL_RED sequencer for NUM_PHASES phases on a 1 s tick.
// Optional PREEMPT_EN macro enables preemption to preempt_phase.
module phase_sequencer #(
    parameter int NUM_PHASES   = 4,
    parameter int PH_W         = 2,
    parameter int TICK_DIV     = 1000,
    parameter int TIMER_W      = 8,
    parameter int GREEN_MAX    = 120,
    parameter int TRUNC_TO     = 30,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2,
    parameter int PED_CLEAR    = 10,
    parameter int RECALL_PHASE = 0
) (
    input logic              clk,
    input logic              rst,
    phase_sequencer_if.slave bus
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_MAX);
    localparam logic [TIMER_W-1:0] T_TRUNC  = TIMER_W'(TRUNC_TO);
    localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TIME);
    localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALL_RED_TIME);
    localparam logic [TIMER_W-1:0] T_PED    = TIMER_W'(PED_CLEAR);
    localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
    localparam logic [PH_W-1:0]    P_RECALL = PH_W'(RECALL_PHASE);
    localparam logic [PH_W-1:0]    P_LAST   = PH_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_t;

    function automatic logic [NUM_PHASES-1:0] phase_mask(input logic [PH_W-1:0] ph);
        phase_mask     = '0;
        phase_mask[ph] = 1'b1;
    endfunction

    // Round-robin from the phase after 'from'; 'from' itself is visited last.
    function automatic logic [PH_W-1:0] pick_next(input logic [NUM_PHASES-1:0] dem,
                                                  input logic [PH_W-1:0] from);
        logic found;
        int   idx;
        pick_next = P_RECALL;
        found     = 1'b0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            idx = (int'(from) + k) % NUM_PHASES;
            if (!found && dem[PH_W'(idx)]) begin
                pick_next = PH_W'(idx);
                found     = 1'b1;
            end
        end
    endfunction

    state_t                state_q, state_d;
    logic [TIMER_W-1:0]    cd_q, cd_d;
    logic [PH_W-1:0]       act_q, act_d, nxt;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [NUM_PHASES-1:0] dem_q, dem_d, ped_q, ped_d;
    logic [NUM_PHASES-1:0] green_q, green_d, yellow_q, yellow_d, walk_q, walk_d;
    logic                  tick, conflict, entry, walk_cap, walk_live;
    logic                  pre_on, pre_force, pre_hold;

    assign tick     = (presc_q == PRE_LAST);
    assign presc_d  = tick ? '0 : presc_q + PRE_W'(1);
    assign conflict = |(dem_q & ~phase_mask(act_q));

    always_comb begin
        state_d   = state_q;
        cd_d      = cd_q;
        act_d     = act_q;
        entry     = 1'b0;
        pre_on    = 1'b0;
        pre_force = 1'b0;
        pre_hold  = 1'b0;
        nxt       = pick_next(dem_q, act_q);
`ifdef PREEMPT_EN
        if (bus.preempt_req) begin
            pre_on = 1'b1;
            nxt    = bus.preempt_phase;
            if (state_q == ST_GREEN) begin
                pre_force = (act_q != bus.preempt_phase);
                pre_hold  = (act_q == bus.preempt_phase);
            end
        end
`endif
        case (state_q)
            ST_ALL_RED: begin
                if (tick) begin
                    if (cd_q == T_ONE) begin
                        state_d = ST_GREEN;
                        cd_d    = T_GREEN;
                        act_d   = nxt;
                        entry   = 1'b1;
                    end else begin
                        cd_d = cd_q - T_ONE;
                    end
                end
            end
            ST_GREEN: begin
                if (pre_force) begin
                    state_d = ST_YELLOW;
                    cd_d    = T_YELLOW;
                end else if (pre_hold) begin
                    cd_d = cd_q;
                end else if (conflict && (cd_q > T_TRUNC)) begin
                    cd_d = T_TRUNC;
                end else if (tick) begin
                    // At countdown 1 with nobody waiting the phase rests in green.
                    if (cd_q != T_ONE) begin
                        cd_d = cd_q - T_ONE;
                    end else if (conflict) begin
                        state_d = ST_YELLOW;
                        cd_d    = T_YELLOW;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (cd_q == T_ONE) begin
                        state_d = ST_ALL_RED;
                        cd_d    = T_ALLRED;
                    end else begin
                        cd_d = cd_q - T_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                cd_d    = T_ALLRED;
            end
        endcase

        // Green phase ignores its own car sensor; entry clear wins over a same-cycle set.
        dem_d    = dem_q | bus.ped_button
                 | (bus.car_sensor & ~((state_q == ST_GREEN) ? phase_mask(act_q) : '0));
        ped_d    = ped_q | bus.ped_button;
        walk_cap = ped_q[nxt] | bus.ped_button[nxt];
        if (entry) begin
            dem_d[nxt] = 1'b0;
            ped_d[nxt] = 1'b0;
        end

        walk_live = (entry ? walk_cap : (|walk_q)) && (state_d == ST_GREEN)
                  && (cd_d > T_PED) && !pre_on;
        green_d   = (state_d == ST_GREEN)  ? phase_mask(act_d) : '0;
        yellow_d  = (state_d == ST_YELLOW) ? phase_mask(act_d) : '0;
        walk_d    = walk_live ? phase_mask(act_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ALL_RED;
            cd_q     <= T_ALLRED;
            act_q    <= P_LAST;
            presc_q  <= '0;
            dem_q    <= '0;
            ped_q    <= '0;
            green_q  <= '0;
            yellow_q <= '0;
            walk_q   <= '0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            act_q    <= act_d;
            presc_q  <= presc_d;
            dem_q    <= dem_d;
            ped_q    <= ped_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            walk_q   <= walk_d;
        end
    end

    assign bus.green        = green_q;
    assign bus.yellow       = yellow_q;
    assign bus.red          = ~(green_q | yellow_q);
    assign bus.walk         = walk_q;
    assign bus.hand         = ~walk_q;
    assign bus.countdown    = cd_q;
    assign bus.active_phase = act_q;
    assign bus.tick         = tick;
endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: hand sequences, a table of demand scenarios,
// and randomized traffic checked every cycle against a behavioural model.
module tb_phase_sequencer;
    localparam int NP = 4, TD = 4, GM = 120, TT = 30, YT = 4, AR = 2, PC = 10, RP = 0;
    localparam int S_RED = 0, S_GRN = 1, S_YEL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_sequencer_if #(.NUM_PHASES(NP), .PH_W(2), .TIMER_W(8)) bus ();

    phase_sequencer #(
        .NUM_PHASES(NP), .PH_W(2), .TICK_DIV(TD), .TIMER_W(8), .GREEN_MAX(GM),
        .TRUNC_TO(TT), .YELLOW_TIME(YT), .ALL_RED_TIME(AR), .PED_CLEAR(PC),
        .RECALL_PHASE(RP)
    ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b1;

    // Behavioural model state
    int m_st, m_cd, m_act, m_presc;
    bit m_dem[NP];
    bit m_ped[NP];
    bit m_walk;

    task automatic model_reset();
        m_st = S_RED; m_cd = AR; m_act = NP - 1; m_presc = 0; m_walk = 0;
        for (int j = 0; j < NP; j++) begin m_dem[j] = 0; m_ped[j] = 0; end
    endtask

    task automatic model_step(input logic [NP-1:0] car, input logic [NP-1:0] pin);
        bit tk, others;
        int old_st, old_act, nx;
        bit old_ped[NP];
        tk = (m_presc == TD - 1);
        m_presc = tk ? 0 : m_presc + 1;
        old_st = m_st; old_act = m_act; others = 0; nx = -1;
        for (int j = 0; j < NP; j++) begin
            old_ped[j] = m_ped[j];
            if (j != m_act && m_dem[j]) others = 1;
        end
        case (m_st)
            S_RED: if (tk) begin
                if (m_cd == 1) begin
                    nx = RP;
                    for (int k = NP; k >= 1; k--) if (m_dem[(m_act + k) % NP]) nx = (m_act + k) % NP;
                    m_st = S_GRN; m_cd = GM; m_act = nx;
                end else m_cd--;
            end
            S_GRN: begin
                if (others && m_cd > TT) m_cd = TT;
                else if (tk) begin
                    if (m_cd > 1) m_cd--;
                    else if (others) begin m_st = S_YEL; m_cd = YT; end
                end
            end
            default: if (tk) begin
                if (m_cd == 1) begin m_st = S_RED; m_cd = AR; end else m_cd--;
            end
        endcase
        for (int j = 0; j < NP; j++) begin
            if (pin[j]) begin m_dem[j] = 1; m_ped[j] = 1; end
            if (car[j] && !(old_st == S_GRN && j == old_act)) m_dem[j] = 1;
        end
        if (nx >= 0) begin
            m_walk = old_ped[nx] || pin[nx];
            m_dem[nx] = 0; m_ped[nx] = 0;
        end
        if (m_st != S_GRN || m_cd <= PC) m_walk = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step(bus.car_sensor, bus.ped_button);
        end
    end

    task automatic check_model();
        logic [NP-1:0] eg, ey, ew;
        logic [30:0] got, exp;
        eg = (m_st == S_GRN) ? (4'b1 << m_act) : 4'b0;
        ey = (m_st == S_YEL) ? (4'b1 << m_act) : 4'b0;
        ew = m_walk ? (4'b1 << m_act) : 4'b0;
        exp = {eg, ey, ~(eg | ey), ew, ~ew, 8'(m_cd), 2'(m_act), (m_presc == TD - 1)};
        got = {bus.green, bus.yellow, bus.red, bus.walk, bus.hand, bus.countdown,
               bus.active_phase, bus.tick};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL model t=%0t: got %h expected %h", $time, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) check_model();
    end

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++; n_bad++;
        $display("FAIL %s: wait budget expired", nm);
    endtask

    task automatic wait_rest();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.countdown == 1 && bus.green != 0) && n < 3000);
        if (n >= 3000) timeout("wait_rest");
    endtask

    task automatic wait_cd(input int v);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.countdown != 8'(v) && n < 3000);
        if (n >= 3000) timeout("wait_cd");
    endtask

    task automatic wait_change(input logic [NP-1:0] prev);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.green != 0 && bus.green != prev) && n < 3000);
        if (n >= 3000) timeout("wait_change");
    endtask

    task automatic pulse(input logic [NP-1:0] c, input logic [NP-1:0] p);
        @(posedge clk); #2; bus.car_sensor = c; bus.ped_button = p;
        @(posedge clk); #2; bus.car_sensor = '0; bus.ped_button = '0;
    endtask

    typedef struct {
        logic [NP-1:0] car;
        logic [NP-1:0] ped;
        int            exp_ph;
        bit            exp_walk;
        bit            chk_clear;
    } rec_t;
    rec_t tbl[9];

    initial begin
        logic [NP-1:0] prev;
        logic [7:0]    tk_pat;
        bit            red_ok;
        int            ny, nr, n;

        // Starting from phase 2 resting; each entry: pulse, then next phase served.
        tbl[0] = '{4'b0000, 4'b0010, 1, 1'b1, 1'b1};
        tbl[1] = '{4'b1001, 4'b0000, 3, 1'b0, 1'b0};
        tbl[2] = '{4'b0000, 4'b0000, 0, 1'b0, 1'b0};
        tbl[3] = '{4'b0100, 4'b0000, 2, 1'b0, 1'b0};
        tbl[4] = '{4'b1010, 4'b0000, 3, 1'b0, 1'b0};
        tbl[5] = '{4'b0000, 4'b0000, 1, 1'b0, 1'b0};
        tbl[6] = '{4'b0000, 4'b0001, 0, 1'b1, 1'b1};
        tbl[7] = '{4'b0010, 4'b1000, 1, 1'b0, 1'b0};
        tbl[8] = '{4'b0000, 4'b0000, 3, 1'b1, 1'b1};

        bus.car_sensor = '0;
        bus.ped_button = '0;
`ifdef PREEMPT_EN
        bus.preempt_req   = 1'b0;
        bus.preempt_phase = '0;
`endif
        @(negedge clk);
        cmp("rst_countdown", 64'(bus.countdown), 64'(AR));
        cmp("rst_active", 64'(bus.active_phase), 64'(NP - 1));
        cmp("rst_red", 64'(bus.red), 64'hf);
        cmp("rst_hand", 64'(bus.hand), 64'hf);
        cmp("rst_tick", 64'(bus.tick), 64'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Power-up all-red lasts two ticks, then recall phase.
        red_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.red != 4'hf || bus.green != 0) red_ok = 1'b0;
            tk_pat[i] = bus.tick;
        end
        @(negedge clk);
        cmp("pwrup_red_8clk", 64'(red_ok), 64'h1);
        cmp("pwrup_tick_pattern", 64'(tk_pat), 64'h88);
        cmp("pwrup_green", 64'(bus.green), 64'h1);
        cmp("pwrup_countdown", 64'(bus.countdown), 64'(GM));

        // Truncation, yellow/all-red timing and skipping of phase 1.
        wait_cd(100);
        pulse(4'b0100, 4'b0000);
        @(negedge clk); @(negedge clk);
        cmp("trunc_countdown", 64'(bus.countdown), 64'(TT));
        n = 0;
        while (bus.yellow == 0 && n < 300) begin n++; @(negedge clk); end
        cmp("trunc_yellow0", 64'(bus.yellow), 64'h1);
        ny = 0;
        while (bus.yellow != 0 && ny < 100) begin ny++; @(negedge clk); end
        nr = 0;
        while (bus.green == 0 && bus.yellow == 0 && nr < 100) begin nr++; @(negedge clk); end
        cmp("yellow_cycles", 64'(ny), 64'(YT * TD));
        cmp("allred_cycles", 64'(nr), 64'(AR * TD));
        cmp("skip_to_green2", 64'(bus.green), 64'h4);
        cmp("skip_active2", 64'(bus.active_phase), 64'h2);

        for (int i = 0; i < 9; i++) begin
            prev = bus.green;
            if (tbl[i].car != 0 || tbl[i].ped != 0) begin
                wait_rest();
                pulse(tbl[i].car, tbl[i].ped);
            end
            wait_change(prev);
            cmp($sformatf("rec%0d_phase", i), 64'(bus.active_phase), 64'(tbl[i].exp_ph));
            cmp($sformatf("rec%0d_green", i), 64'(bus.green), 64'(4'b1 << tbl[i].exp_ph));
            cmp($sformatf("rec%0d_walk", i), 64'(bus.walk),
                tbl[i].exp_walk ? 64'(4'b1 << tbl[i].exp_ph) : 64'h0);
            if (tbl[i].chk_clear) begin
                wait_cd(PC + 1);
                cmp($sformatf("rec%0d_walk_at11", i), 64'(bus.walk), 64'(4'b1 << tbl[i].exp_ph));
                wait_cd(PC);
                cmp($sformatf("rec%0d_walk_at10", i), 64'(bus.walk), 64'h0);
                cmp($sformatf("rec%0d_hand_at10", i), 64'(bus.hand), 64'hf);
            end
        end

        // Resting phase 3, car on phase 1 held as a level.
        wait_rest();
        @(posedge clk); #2 bus.car_sensor = 4'b0010;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.yellow == 0 && n < 20);
        cmp("rest_yellow_latency_ok", 64'(n >= 3 && n <= 6), 64'h1);
        cmp("rest_yellow3", 64'(bus.yellow), 64'h8);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.green == 0 && n < 100);
        cmp("rest_to_green_cycles", 64'(n), 64'((YT + AR) * TD));
        cmp("rest_green1", 64'(bus.green), 64'h2);
        @(posedge clk); #2 bus.car_sensor = '0;

        // Reset in the middle of yellow.
        pulse(4'b0100, 4'b0000);
        n = 0;
        while (bus.yellow == 0 && n < 400) begin n++; @(negedge clk); end
        if (n >= 400) timeout("wait_yellow");
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        cmp("midrst_yellow_now", 64'(bus.yellow), 64'h0);
        cmp("midrst_countdown_now", 64'(bus.countdown), 64'(AR));
        @(negedge clk);
        cmp("midrst_green", 64'(bus.green), 64'h0);
        cmp("midrst_red", 64'(bus.red), 64'hf);
        cmp("midrst_active", 64'(bus.active_phase), 64'(NP - 1));
        @(posedge clk); #2 rst = 1'b0;

        // Randomized traffic, checked every cycle against the model.
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #2;
            bus.car_sensor = '0;
            bus.ped_button = '0;
            n = $urandom % 100;
            if (n < 3) bus.car_sensor[$urandom % NP] = 1'b1;
            if (n == 50) bus.ped_button[$urandom % NP] = 1'b1;
            if (n == 60) bus.car_sensor = 4'($urandom);
            rst = ($urandom % 6000 == 0);
        end
        @(posedge clk); #2 rst = 1'b0; bus.car_sensor = '0; bus.ped_button = '0;
        repeat (4) @(negedge clk);

`ifdef PREEMPT_EN
        chk_en = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.green == 0 && n < 50);
        cmp("pre_start_green0", 64'(bus.green), 64'h1);
        @(posedge clk); #2 bus.preempt_phase = 2'd3; bus.preempt_req = 1'b1;
        @(posedge clk); #1;
        cmp("pre_yellow0", 64'(bus.yellow), 64'h1);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.green == 0 && n < 200);
        cmp("pre_green3", 64'(bus.green), 64'h8);
        repeat (40) @(negedge clk);
        cmp("pre_hold_green3", 64'(bus.green), 64'h8);
        cmp("pre_hold_countdown", 64'(bus.countdown), 64'(GM));
        cmp("pre_walk_off", 64'(bus.walk), 64'h0);
        bus.preempt_req = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
